// File: rtl/sanity_pkg.sv
// sanity_pkg -- shared definitions for the sanity watchdog.
//   state_t      : watchdog FSM state encoding
//   CNT_W        : width of the remaining-count register
//   sanity_load  : decode of the sanity count select into a reload value
package sanity_pkg;

   localparam int CNT_W = 7;

   typedef enum logic [1:0] {
      ST_DISABLED = 2'd0,
      ST_RUN      = 2'd1,
      ST_FIRE     = 2'd2,
      ST_DONE     = 2'd3
   } state_t;

   // Count select: 00 -> 1, 01 -> 4, 10 -> 16, 11 -> 64 ticks.
   function automatic logic [CNT_W-1:0] sanity_load(input logic [1:0] sel);
      logic [CNT_W-1:0] val;
      case (sel)
         2'b00:   val = 7'd1;
         2'b01:   val = 7'd4;
         2'b10:   val = 7'd16;
         2'b11:   val = 7'd64;
         default: val = 7'd1;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/sanity_wdt_tick_div.sv
// tick_div -- free-running divider producing a one-clock strobe every LIMIT
// enabled clocks.
//   clock : system clock
//   rst   : synchronous active-high reset
//   clr   : synchronous clear of the divider count
//   en    : count enable; the count holds while low
//   tick  : one-clock strobe on the enabled clock that completes LIMIT counts
module tick_div #(
   parameter int LIMIT = 4
) (
   input  logic clock,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

   logic [W-1:0] cnt_r;
   logic         at_limit_s;

   assign at_limit_s = (cnt_r == W'(LIMIT - 1));
   // The strobe is combinational so the consumer sees it on the same edge
   // the count wraps.
   assign tick = en & at_limit_s;

   // Divider count: cleared by reset or clr, wraps after LIMIT enabled clocks.
   always_ff @(posedge clock) begin
      if (rst || clr) begin
         cnt_r <= {W{1'b0}};
      end else if (en) begin
         if (at_limit_s) begin
            cnt_r <= {W{1'b0}};
         end else begin
            cnt_r <= cnt_r + W'(1);
         end
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/sanity_wdt.sv
// sanity_wdt -- host sanity watchdog. Counts down a programmable number of
// quarter-second or minute ticks and drives a fixed-width low pulse on
// bdcok_n when the host fails to kick in time.
//   clock      : system clock (all logic on this clock)
//   rst        : synchronous active-high reset
//   sanity     : [2] minute base (1) / quarter-second base (0), [1:0] count
//   ena        : timer enable
//   kick       : single-cycle restart strobe
//   auto_rearm : reload after a pulse (1) or stop in DONE (0)
//   clr        : clears the sticky expired flag
//   bdcok_n    : low for PULSE_CYCLES clocks on expiry
//   expired    : sticky expiry flag
//   cnt        : remaining tick count
module sanity_wdt
   import sanity_pkg::*;
#(
   parameter int CLK_HZ       = 2500000,
   parameter int QSEC_DIV     = CLK_HZ / 4,
   parameter int MIN_TICKS    = 240,
   parameter int PULSE_CYCLES = 10
) (
   input  logic             clock,
   input  logic             rst,
   input  logic [2:0]       sanity,
   input  logic             ena,
   input  logic             kick,
   input  logic             auto_rearm,
   input  logic             clr,
   output logic             bdcok_n,
   output logic             expired,
   output logic [CNT_W-1:0] cnt
);

   localparam int PULSE_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

   state_t             state_r;
   logic [PULSE_W-1:0] pulse_cnt_r;
   logic               base_r;
   logic [CNT_W-1:0]   cnt_r;
   logic               bdcok_n_r;
   logic               expired_r;

   logic               qtick_s;
   logic               mtick_s;
   logic               sel_tick_s;
   logic               load_s;
   logic               fire_entry_s;
   logic               div_clr_s;
   logic               pulse_last_s;
   logic [CNT_W-1:0]   load_val_s;

   assign load_val_s   = sanity_load(sanity[1:0]);
   assign sel_tick_s   = base_r ? mtick_s : qtick_s;
   // Pulse counter stops at PULSE_CYCLES-1, so it can never wrap.
   assign pulse_last_s = (pulse_cnt_r == PULSE_W'(PULSE_CYCLES - 1));
   // Any load restarts both prescalers, so the first tick is a full period away.
   assign div_clr_s    = load_s | ~ena;

   assign bdcok_n = bdcok_n_r;
   assign expired = expired_r;
   assign cnt     = cnt_r;

   // Load and expiry decode shared by the FSM and the prescaler clear.
   always_comb begin
      load_s       = 1'b0;
      fire_entry_s = 1'b0;
      case (state_r)
         ST_DISABLED: begin
            load_s = ena;
         end
         ST_RUN: begin
            // kick takes priority over the tick, including the expiring one
            load_s       = ena & kick;
            fire_entry_s = ena & ~kick & sel_tick_s & (cnt_r <= 7'd1);
         end
         ST_FIRE: begin
            load_s = pulse_last_s & auto_rearm & ena;
         end
         ST_DONE: begin
            load_s = ena & kick;
         end
         default: begin
            load_s       = 1'b0;
            fire_entry_s = 1'b0;
         end
      endcase
   end

   tick_div #(.LIMIT(QSEC_DIV)) u_qdiv (
      .clock (clock),
      .rst   (rst),
      .clr   (div_clr_s),
      .en    (ena),
      .tick  (qtick_s)
   );

   tick_div #(.LIMIT(MIN_TICKS)) u_mdiv (
      .clock (clock),
      .rst   (rst),
      .clr   (div_clr_s),
      .en    (qtick_s),
      .tick  (mtick_s)
   );

   // Watchdog FSM with registered count, pulse and expiry outputs.
   always_ff @(posedge clock) begin
      if (rst) begin
         state_r     <= ST_DISABLED;
         pulse_cnt_r <= {PULSE_W{1'b0}};
         base_r      <= 1'b0;
         cnt_r       <= 7'd0;
         bdcok_n_r   <= 1'b1;
         expired_r   <= 1'b0;
      end else begin
         // set wins over a simultaneous clear
         if (fire_entry_s) begin
            expired_r <= 1'b1;
         end else if (clr) begin
            expired_r <= 1'b0;
         end else begin
            expired_r <= expired_r;
         end

         case (state_r)
            ST_DISABLED: begin
               bdcok_n_r <= 1'b1;
               cnt_r     <= load_val_s;
               if (ena) begin
                  base_r  <= sanity[2];
                  state_r <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (!ena) begin
                  cnt_r   <= load_val_s;
                  state_r <= ST_DISABLED;
               end else if (load_s) begin
                  cnt_r  <= load_val_s;
                  base_r <= sanity[2];
               end else if (fire_entry_s) begin
                  cnt_r       <= 7'd0;
                  pulse_cnt_r <= {PULSE_W{1'b0}};
                  bdcok_n_r   <= 1'b0;
                  state_r     <= ST_FIRE;
               end else if (sel_tick_s) begin
                  cnt_r <= cnt_r - 7'd1;
               end
            end
            ST_FIRE: begin
               // kick and ena are ignored until the pulse has run its course
               if (pulse_last_s) begin
                  bdcok_n_r <= 1'b1;
                  if (load_s) begin
                     cnt_r   <= load_val_s;
                     base_r  <= sanity[2];
                     state_r <= ST_RUN;
                  end else if (!ena) begin
                     cnt_r   <= load_val_s;
                     state_r <= ST_DISABLED;
                  end else begin
                     state_r <= ST_DONE;
                  end
               end else begin
                  pulse_cnt_r <= pulse_cnt_r + PULSE_W'(1);
               end
            end
            ST_DONE: begin
               bdcok_n_r <= 1'b1;
               if (!ena) begin
                  cnt_r   <= load_val_s;
                  state_r <= ST_DISABLED;
               end else if (load_s) begin
                  cnt_r   <= load_val_s;
                  base_r  <= sanity[2];
                  state_r <= ST_RUN;
               end
            end
            default: begin
               cnt_r     <= 7'd0;
               bdcok_n_r <= 1'b1;
               state_r   <= ST_DISABLED;
            end
         endcase
      end
   end

endmodule
